// File: rtl/code_entry_compare.sv
// Keypad entry buffer and serial code comparator for the lock controller.
// Latches symbols, snapshots candidates on commands, compares against PC/user/staging codes.
module code_entry_compare #(
    parameter int                   MAX_LEN    = 8,
    parameter int                   MIN_UC_LEN = 4,
    parameter int                   PC_LEN     = 4,
    parameter logic [4*MAX_LEN-1:0] PC_CODE    = 32'h0000_4321,
    parameter logic [4*MAX_LEN-1:0] DEF_UC     = 32'h0000_0000,
    parameter int                   DEF_UC_LEN = 4
) (
    input  logic       hwclk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       read_input,
    input  logic [1:0] compareType,
    input  logic       store,
    output logic       validLength,
    output logic       validLengthPC,
    output logic       data_ready,
    output logic       correct_input,
    output logic [3:0] entry_count
);

    localparam int         W     = 4 * MAX_LEN;
    localparam logic [3:0] MAX_C = 4'(MAX_LEN);
    localparam logic [3:0] MIN_C = 4'(MIN_UC_LEN);
    localparam logic [3:0] PC_C  = 4'(PC_LEN);
    localparam logic [3:0] DEF_C = 4'(DEF_UC_LEN);

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        DONE
    } state_t;

    logic [W-1:0] entry;
    logic [3:0]   count;
    logic         ovf;

    logic [W-1:0] cand;
    logic [3:0]   cand_len;
    logic         cand_ovf;

    logic [W-1:0] stage;
    logic [3:0]   stage_len;

    logic [W-1:0] uc;
    logic [3:0]   uc_len;
    logic         store_q;

    state_t       state;
    logic         prev_ri;
    logic [3:0]   idx;
    logic         mm;
    logic         skip;
    logic [W-1:0] ref_code;
    logic [3:0]   ref_len;

    logic         is_cmd7;
    logic         is_snap;
    logic         is_sym;
    logic         ri_rise;
    logic         ri_fall;
    logic         clear_entry;
    logic [W-1:0] sel_code;
    logic [3:0]   sel_len;
    logic         sel_short;
    logic         sym_ne;
    logic         last_sym;

    assign is_cmd7 = key_valid && (key_code == 4'd7);
    assign is_snap = key_valid && read_input
                     && ((key_code == 4'd8) || (key_code == 4'd9));
    assign is_sym  = key_valid && (key_code != 4'd7)
                     && (key_code != 4'd8) && (key_code != 4'd9);

    assign ri_rise = read_input && !prev_ri;
    assign ri_fall = !read_input && prev_ri;

    assign clear_entry = is_cmd7 || ri_rise || is_snap;

    assign validLength   = !ovf && (count >= MIN_C) && (count <= MAX_C);
    assign validLengthPC = !ovf && (count == PC_C);
    assign entry_count   = count;

    always_comb begin
        sel_code = stage;
        sel_len  = stage_len;
        unique case (compareType)
            2'b00: begin
                sel_code = PC_CODE;
                sel_len  = PC_C;
            end
            2'b01: begin
                sel_code = uc;
                sel_len  = uc_len;
            end
            default: begin
                sel_code = stage;
                sel_len  = stage_len;
            end
        endcase
    end

    // Early exit: overflow, length mismatch or an empty reference need no symbol walk.
    assign sel_short = cand_ovf || (cand_len != sel_len) || (sel_len == 4'd0);

    assign sym_ne   = cand[4*idx +: 4] != ref_code[4*idx +: 4];
    assign last_sym = idx == (ref_len - 4'd1);

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            entry <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (clear_entry) begin
            entry <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (is_sym && read_input) begin
            if (count == MAX_C) begin
                ovf <= 1'b1;
            end else begin
                entry[4*count +: 4] <= key_code;
                count               <= count + 4'd1;
            end
        end
    end

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            cand      <= '0;
            cand_len  <= '0;
            cand_ovf  <= 1'b0;
            stage     <= '0;
            stage_len <= '0;
        end else if (is_snap) begin
            cand     <= entry;
            cand_len <= count;
            cand_ovf <= ovf;
            if (compareType == 2'b11) begin
                stage     <= entry;
                stage_len <= count;
            end
        end
    end

    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            uc      <= DEF_UC;
            uc_len  <= DEF_C;
            store_q <= 1'b0;
        end else begin
            store_q <= store;
            if (store && !store_q) begin
                uc     <= stage;
                uc_len <= stage_len;
            end
        end
    end

    // Reference is latched at the fall so a concurrent store cannot disturb the compare.
    always_ff @(posedge hwclk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            prev_ri       <= 1'b0;
            idx           <= '0;
            mm            <= 1'b0;
            skip          <= 1'b0;
            ref_code      <= '0;
            ref_len       <= '0;
            data_ready    <= 1'b0;
            correct_input <= 1'b0;
        end else begin
            prev_ri <= read_input;
            if (is_cmd7 || ri_rise) begin
                state         <= IDLE;
                data_ready    <= 1'b0;
                correct_input <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (ri_fall) begin
                            state    <= CMP;
                            idx      <= '0;
                            ref_code <= sel_code;
                            ref_len  <= sel_len;
                            skip     <= sel_short;
                            mm       <= cand_ovf || (cand_len != sel_len);
                        end
                    end
                    CMP: begin
                        if (skip || last_sym) begin
                            state         <= DONE;
                            data_ready    <= 1'b1;
                            correct_input <= !(mm || (!skip && sym_ne));
                        end else begin
                            idx <= idx + 4'd1;
                            mm  <= mm || sym_ne;
                        end
                    end
                    DONE: begin
                        data_ready <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_code_entry_compare.sv
// Randomized and directed bench for code_entry_compare against a queue-based model.
module tb_code_entry_compare;

    logic       hwclk = 1'b0;
    logic       rst;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       read_input = 1'b0;
    logic [1:0] compareType = 2'd0;
    logic       store = 1'b0;
    logic       validLength;
    logic       validLengthPC;
    logic       data_ready;
    logic       correct_input;
    logic [3:0] entry_count;

    int checks = 0;
    int failures = 0;

    code_entry_compare dut (
        .hwclk        (hwclk),
        .rst          (rst),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .read_input   (read_input),
        .compareType  (compareType),
        .store        (store),
        .validLength  (validLength),
        .validLengthPC(validLengthPC),
        .data_ready   (data_ready),
        .correct_input(correct_input),
        .entry_count  (entry_count)
    );

    always #5 hwclk = ~hwclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: entries are symbol queues, compare latency is a countdown.
    logic [3:0] m_ent[$];
    logic [3:0] m_cand[$];
    logic [3:0] m_stage[$];
    logic [3:0] m_uc[$];
    logic [3:0] m_ref[$];
    bit m_ovf, m_cand_ovf, m_prev_ri, m_prev_st;
    bit m_pend, m_ready, m_corr, m_res;
    int m_wait;

    function automatic bit same(input logic [3:0] a[$], input logic [3:0] b[$]);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge hwclk or posedge rst) begin
        bit c7, snap, sym, rise, fall;
        if (rst) begin
            m_ent.delete();
            m_cand.delete();
            m_stage.delete();
            m_uc = '{4'd0, 4'd0, 4'd0, 4'd0};
            m_ovf = 0; m_cand_ovf = 0; m_prev_ri = 0; m_prev_st = 0;
            m_pend = 0; m_ready = 0; m_corr = 0; m_wait = 0;
        end else begin
            c7   = key_valid && key_code == 4'd7;
            snap = key_valid && read_input && (key_code == 4'd8 || key_code == 4'd9);
            sym  = key_valid && !(key_code inside {4'd7, 4'd8, 4'd9});
            rise = read_input && !m_prev_ri;
            fall = !read_input && m_prev_ri;
            if (c7 || rise) begin
                m_pend = 0; m_ready = 0;
            end else if (m_pend) begin
                m_wait--;
                if (m_wait == 0) begin
                    m_pend = 0; m_ready = 1; m_corr = m_res;
                end
            end else if (!m_ready && fall) begin
                case (compareType)
                    2'd0: m_ref = '{4'd1, 4'd2, 4'd3, 4'd4};
                    2'd1: m_ref = m_uc;
                    default: m_ref = m_stage;
                endcase
                m_res  = !m_cand_ovf && same(m_cand, m_ref);
                m_wait = (m_cand_ovf || m_cand.size() != m_ref.size() || m_ref.size() == 0)
                         ? 1 : m_ref.size();
                m_pend = 1;
            end
            if (store && !m_prev_st) m_uc = m_stage;
            m_prev_st = store;
            if (snap) begin
                m_cand = m_ent;
                m_cand_ovf = m_ovf;
                if (compareType == 2'd3) m_stage = m_ent;
            end
            if (c7 || rise || snap) begin
                m_ent.delete();
                m_ovf = 0;
            end else if (sym && read_input) begin
                if (m_ent.size() == 8) m_ovf = 1;
                else m_ent.push_back(key_code);
            end
            m_prev_ri = read_input;
        end
    end

    always @(negedge hwclk) begin
        int n;
        n = m_ent.size();
        chk("entry_count", 32'(entry_count), 32'(n));
        chk("validLength", 32'(validLength), 32'(!m_ovf && n >= 4 && n <= 8));
        chk("validLengthPC", 32'(validLengthPC), 32'(!m_ovf && n == 4));
        chk("data_ready", 32'(data_ready), 32'(m_ready));
        if (m_ready) chk("correct_input", 32'(correct_input), 32'(m_corr));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge hwclk);
    endtask

    task automatic key(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge hwclk);
        key_valid = 1'b0;
    endtask

    task automatic keys4(input logic [3:0] a, b, c, d);
        key(a); key(b); key(c); key(d);
    endtask

    initial begin
        rst = 1'b1;
        cyc(2);
        chk("rst_data_ready", 32'(data_ready), 0);
        chk("rst_count", 32'(entry_count), 0);
        chk("rst_vl", 32'(validLength), 0);
        chk("rst_vlpc", 32'(validLengthPC), 0);
        rst = 1'b0;

        read_input = 1'b1; cyc(1);
        keys4(1, 2, 3, 4);
        chk("t1_vlpc", 32'(validLengthPC), 1);
        chk("t1_count", 32'(entry_count), 4);
        key(8);
        read_input = 1'b0;
        cyc(4);
        chk("t1_dr_early", 32'(data_ready), 0);
        cyc(1);
        chk("t1_dr", 32'(data_ready), 1);
        chk("t1_correct", 32'(correct_input), 1);
        read_input = 1'b1; cyc(1);
        chk("t1_dr_clear", 32'(data_ready), 0);

        keys4(1, 2, 3, 5); key(8);
        read_input = 1'b0; cyc(5);
        chk("t2_dr", 32'(data_ready), 1);
        chk("t2_correct", 32'(correct_input), 0);
        read_input = 1'b1; cyc(1);
        key(1); key(2); key(3);
        chk("t2_vlpc", 32'(validLengthPC), 0);
        chk("t2_vl", 32'(validLength), 0);

        compareType = 2'd1;
        key(7);
        key(1); key(2); key(3); key(9);
        read_input = 1'b0; cyc(1);
        chk("t3_dr_early", 32'(data_ready), 0);
        cyc(1);
        chk("t3_dr", 32'(data_ready), 1);
        chk("t3_correct", 32'(correct_input), 0);

        read_input = 1'b1; compareType = 2'd3; cyc(1);
        keys4(5, 6, 0, 1); key(8);
        read_input = 1'b0; cyc(6);
        read_input = 1'b1; compareType = 2'd2; cyc(1);
        keys4(5, 6, 0, 1); key(8);
        read_input = 1'b0; cyc(5);
        chk("t4_match_dr", 32'(data_ready), 1);
        chk("t4_match_correct", 32'(correct_input), 1);
        store = 1'b1; cyc(3); store = 1'b0;
        read_input = 1'b1; compareType = 2'd1; cyc(1);
        keys4(5, 6, 0, 1); key(9);
        read_input = 1'b0; cyc(5);
        chk("t4_uc_dr", 32'(data_ready), 1);
        chk("t4_uc_correct", 32'(correct_input), 1);
        read_input = 1'b1; cyc(1);
        keys4(0, 0, 0, 0); key(9);
        read_input = 1'b0; cyc(5);
        chk("t4_old_dr", 32'(data_ready), 1);
        chk("t4_old_correct", 32'(correct_input), 0);

        read_input = 1'b1; cyc(1);
        keys4(1, 2, 3, 4); keys4(5, 6, 0, 1); key(2);
        chk("t5_count", 32'(entry_count), 8);
        chk("t5_vl", 32'(validLength), 0);
        key(7);
        chk("t5_clear", 32'(entry_count), 0);

        keys4(0, 0, 0, 0); key(9);
        read_input = 1'b0; cyc(2);
        #2 rst = 1'b1;
        #1;
        chk("t6_dr", 32'(data_ready), 0);
        chk("t6_count", 32'(entry_count), 0);
        @(negedge hwclk);
        rst = 1'b0;
        read_input = 1'b1; cyc(1);
        keys4(0, 0, 0, 0); key(9);
        read_input = 1'b0; cyc(5);
        chk("t6_def_dr", 32'(data_ready), 1);
        chk("t6_def_correct", 32'(correct_input), 1);

        for (int i = 0; i < 4000; i++) begin
            int r;
            @(negedge hwclk);
            r = $urandom_range(0, 99);
            key_valid = $urandom_range(0, 99) < 40;
            if (r < 60)      key_code = 4'($urandom_range(0, 3));
            else if (r < 85) key_code = 4'($urandom_range(8, 9));
            else if (r < 90) key_code = 4'd7;
            else             key_code = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 6) read_input = ~read_input;
            if ($urandom_range(0, 99) < 5) compareType = 2'($urandom_range(0, 3));
            store = $urandom_range(0, 99) < 4;
        end
        key_valid = 1'b0;
        store = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
